// File: rtl/fifo_rd_sched.sv
// Read-side scheduler: round-robin arbiter with bounded bursts across NUM_Q
// dual-clock FIFO read ports (normal read mode, data one cycle after rreq),
// feeding a 2-entry valid/ready output buffer.
module fifo_rd_sched #(
   parameter int NUM_Q     = 4,
   parameter int QID_W     = 2,
   parameter int DATA_W    = 64,
   parameter int USEDW_W   = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                       clock,
   input  logic                       sclr,
   input  logic [NUM_Q-1:0]           q_empty,
   input  logic [NUM_Q*USEDW_W-1:0]   q_usedw,
   input  logic [NUM_Q*DATA_W-1:0]    q_data,
   output logic [NUM_Q-1:0]           q_rreq,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [QID_W-1:0]           out_qid
);

   localparam int CNT_W = 4;

   typedef enum logic {IDLE, BURST} state_t;

   state_t               state_q, state_d;
   logic [QID_W-1:0]     cur_q, cur_d;
   logic [QID_W-1:0]     rr_q, rr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [NUM_Q-1:0]     rd_last_q;
   logic                 inflight_q;
   logic [QID_W-1:0]     qid_pipe_q;
   logic [1:0]           occ_q, occ_d;
   logic [DATA_W-1:0]    dat0_q, dat0_d, dat1_q, dat1_d;
   logic [QID_W-1:0]     qid0_q, qid0_d, qid1_q, qid1_d;

   logic [NUM_Q-1:0]     elig;
   logic [QID_W-1:0]     rr_idx [NUM_Q];
   logic                 found;
   logic [QID_W-1:0]     srch;
   logic                 pop, push, can_issue;
   logic [2:0]           cred;
   logic                 gnt_vld;
   logic [QID_W-1:0]     gnt_id;
   logic [DATA_W-1:0]    push_data;
   logic [1:0]           wr_base;

   assign out_valid = (occ_q != 2'd0);
   assign out_data  = dat0_q;
   assign out_qid   = qid0_q;
   assign pop       = out_valid && out_ready;
   assign push      = inflight_q;
   assign push_data = q_data[int'(qid_pipe_q)*DATA_W +: DATA_W];

   // Eligibility: usedw/empty lag one cycle behind a read, so a queue read
   // last cycle with fewer than 2 words left may already be drained.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_Q; i++)
         elig[i] = !q_empty[i] &&
                   !(rd_last_q[i] && (q_usedw[i*USEDW_W +: USEDW_W] < USEDW_W'(2)));
   end

   // Round-robin search starting at the rr pointer; the locked queue sits
   // last in this order, so it is only picked again when nothing else is ready.
   always_comb begin
      found = 1'b0;
      srch  = '0;
      for (int k = 0; k < NUM_Q; k++) begin
         rr_idx[k] = QID_W'((int'(rr_q) + k) % NUM_Q);
         if (!found && elig[rr_idx[k]]) begin
            found = 1'b1;
            srch  = rr_idx[k];
         end
      end
   end

   // Credit: words in the buffer plus the read in flight, net of this
   // cycle's pop, must leave room for one more.
   always_comb begin
      cred      = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
      can_issue = (cred < 3'd2);
   end

   // Grant decision and next arbitration state.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = cur_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (can_issue && found) begin
               gnt_vld = 1'b1;
               gnt_id  = srch;
               cnt_d   = CNT_W'(1);
               state_d = BURST;
            end
         end
         BURST: begin
            if (can_issue && elig[cur_q] && (cnt_q < CNT_W'(MAX_BURST))) begin
               gnt_vld = 1'b1;
               gnt_id  = cur_q;
               cnt_d   = cnt_q + CNT_W'(1);
            end else if (can_issue && found) begin
               gnt_vld = 1'b1;
               gnt_id  = srch;
               cnt_d   = CNT_W'(1);
            end else if (!can_issue && elig[cur_q]) begin
               cnt_d   = cnt_q;
            end else begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      cur_d = gnt_vld ? gnt_id : cur_q;
      if (gnt_vld)
         rr_d = (gnt_id == QID_W'(NUM_Q-1)) ? '0 : gnt_id + 1'b1;
      else
         rr_d = rr_q;
      q_rreq = '0;
      if (gnt_vld)
         q_rreq[gnt_id] = 1'b1;
   end

   // Output buffer next state: head shifts on pop, returned word lands in
   // the first free slot after the pop.
   always_comb begin
      dat0_d  = dat0_q;
      dat1_d  = dat1_q;
      qid0_d  = qid0_q;
      qid1_d  = qid1_q;
      wr_base = occ_q - 2'(pop);
      if (pop) begin
         dat0_d = dat1_q;
         qid0_d = qid1_q;
      end
      if (push) begin
         if (wr_base != 2'd0) begin
            dat1_d = push_data;
            qid1_d = qid_pipe_q;
         end else begin
            dat0_d = push_data;
            qid0_d = qid_pipe_q;
         end
      end
      occ_d = occ_q + 2'(push) - 2'(pop);
   end

   // State registers; a read issued in the reset cycle is dropped by
   // clearing inflight, but rd_last still records it so the drained queue
   // is not read again right after reset.
   always_ff @(posedge clock) begin
      rd_last_q <= q_rreq;
      if (sclr) begin
         state_q    <= IDLE;
         cur_q      <= '0;
         rr_q       <= '0;
         cnt_q      <= '0;
         inflight_q <= 1'b0;
         qid_pipe_q <= '0;
         occ_q      <= 2'd0;
         dat0_q     <= '0;
         dat1_q     <= '0;
         qid0_q     <= '0;
         qid1_q     <= '0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         rr_q       <= rr_d;
         cnt_q      <= cnt_d;
         inflight_q <= gnt_vld;
         qid_pipe_q <= gnt_vld ? gnt_id : qid_pipe_q;
         occ_q      <= occ_d;
         dat0_q     <= dat0_d;
         dat1_q     <= dat1_d;
         qid0_q     <= qid0_d;
         qid1_q     <= qid1_d;
      end
   end

   a_no_overflow: assert property (@(posedge clock) disable iff (sclr)
                                   !(push && (occ_q == 2'd2) && !pop));

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Bench for fifo_rd_sched: behavioural read-side FIFO models with one-cycle
// flag lag, a grant log, and a scoreboard of words in read order.
module tb_fifo_rd_sched;
   localparam int NUM_Q = 4, QID_W = 2, DATA_W = 64, USEDW_W = 8, MAX_BURST = 4;
   localparam int DEPTH = 64;

   logic                     clock = 1'b0;
   logic                     sclr = 1'b1;
   logic                     out_ready = 1'b1;
   logic [NUM_Q-1:0]         q_empty = '1;
   logic [NUM_Q*USEDW_W-1:0] q_usedw = '0;
   logic [NUM_Q*DATA_W-1:0]  q_data = '0;
   logic [NUM_Q-1:0]         q_rreq;
   logic                     out_valid;
   logic [DATA_W-1:0]        out_data;
   logic [QID_W-1:0]         out_qid;

   int nvec = 0, nerr = 0;
   logic [DATA_W-1:0] mem [NUM_Q][DEPTH];
   int wr_p [NUM_Q];
   int rd_p [NUM_Q];
   int seq = 0, outs = 0, pending = 0;
   logic [DATA_W-1:0] exp_data [$];
   logic [QID_W-1:0]  exp_qid [$];
   int                glog [$];
   bit                vlog [$];
   logic [QID_W-1:0]  olog [$];
   logic [NUM_Q-1:0]  rreq_s = '0;
   bit                pop_s = 1'b0, sclr_s = 1'b0;

   fifo_rd_sched #(.NUM_Q(NUM_Q), .QID_W(QID_W), .DATA_W(DATA_W),
                   .USEDW_W(USEDW_W), .MAX_BURST(MAX_BURST)) dut (
      .clock(clock), .sclr(sclr), .q_empty(q_empty), .q_usedw(q_usedw),
      .q_data(q_data), .q_rreq(q_rreq), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_qid(out_qid));

   always #5 clock = ~clock;

   // FIFO read-side models: flags show the occupancy before the previous
   // edge's read; each read is pushed to the scoreboard in read order.
   always @(posedge clock) begin
      for (int i = 0; i < NUM_Q; i++) begin
         q_usedw[i*USEDW_W +: USEDW_W] <= USEDW_W'(wr_p[i] - rd_p[i]);
         q_empty[i] <= (wr_p[i] == rd_p[i]);
         if (rreq_s[i] && (wr_p[i] != rd_p[i])) begin
            q_data[i*DATA_W +: DATA_W] <= mem[i][rd_p[i]];
            exp_data.push_back(mem[i][rd_p[i]]);
            exp_qid.push_back(QID_W'(i));
            rd_p[i] <= rd_p[i] + 1;
         end
      end
      pending <= sclr_s ? 0 : pending + int'(rreq_s != '0) - int'(pop_s);
      if (sclr_s) begin
         exp_data.delete();
         exp_qid.delete();
      end
   end

   // Mid-cycle monitor: logs grants, checks one-hot, no read of a drained
   // queue, credit bound, and output words against the scoreboard.
   always @(negedge clock) begin
      int g;
      logic [DATA_W-1:0] ed;
      logic [QID_W-1:0]  eq;
      rreq_s <= q_rreq;
      pop_s  <= out_valid && out_ready;
      sclr_s <= sclr;
      g = -1;
      for (int i = 0; i < NUM_Q; i++) if (q_rreq[i]) g = i;
      glog.push_back(g);
      vlog.push_back(out_valid);
      if (!sclr) begin
         nvec++;
         if ($countones(q_rreq) > 1) begin
            nerr++; $display("FAIL rreq_onehot: got %b required at most one bit", q_rreq);
         end
         for (int i = 0; i < NUM_Q; i++) begin
            if (q_rreq[i]) begin
               nvec++;
               if (wr_p[i] == rd_p[i]) begin
                  nerr++; $display("FAIL read_empty: q%0d read with 0 words, required no read", i);
               end
            end
         end
         nvec++;
         if (pending > 2) begin
            nerr++; $display("FAIL credit: occ+inflight %0d required <= 2", pending);
         end
         if (out_valid && out_ready) begin
            nvec++;
            if (exp_data.size() == 0) begin
               nerr++; $display("FAIL unexpected_out: got qid %0d data %h, required no word", out_qid, out_data);
            end else begin
               ed = exp_data.pop_front();
               eq = exp_qid.pop_front();
               if (out_data !== ed || out_qid !== eq) begin
                  nerr++; $display("FAIL out_word: got q%0d %h required q%0d %h", out_qid, out_data, eq, ed);
               end
            end
            olog.push_back(out_qid);
            outs++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time %0t exceeded, required finish earlier", $time);
      $fatal(1);
   end

   task automatic step();
      @(posedge clock); #1;
   endtask

   task automatic pulse_reset();
      sclr = 1'b1; step(); sclr = 1'b0;
   endtask

   task automatic fill(input int q, input int n);
      for (int k = 0; k < n; k++) begin
         mem[q][wr_p[q]] = {8'(q), 24'(seq), 32'($urandom)};
         wr_p[q]++;
         seq++;
      end
   endtask

   task automatic test_reset();
      sclr = 1'b1; out_ready = 1'b1;
      repeat (3) step();
      @(negedge clock);
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b required 0", out_valid); end
      nvec++; if (q_rreq !== '0) begin nerr++; $display("FAIL reset_rreq: got %b required 0", q_rreq); end
      nvec++; if (out_data !== '0) begin nerr++; $display("FAIL reset_data: got %h required 0", out_data); end
      nvec++; if (out_qid !== '0) begin nerr++; $display("FAIL reset_qid: got %0d required 0", out_qid); end
      step(); sclr = 1'b0;
   endtask

   task automatic test_single_stream();
      int base, first_v, eg;
      pulse_reset(); step();
      base = outs; glog.delete(); vlog.delete();
      fill(0, 10);
      repeat (20) step();
      for (int i = 0; i < 20; i++) begin
         eg = (i >= 1 && i <= 10) ? 0 : -1;
         nvec++;
         if (glog[i] !== eg) begin nerr++; $display("FAIL single_grant[%0d]: got %0d required %0d", i, glog[i], eg); end
      end
      first_v = -1;
      for (int i = 0; i < 20; i++) if (vlog[i] && first_v < 0) first_v = i;
      nvec++; if (first_v !== 3) begin nerr++; $display("FAIL single_latency: first valid cycle %0d required 3", first_v); end
      nvec++; if (outs - base !== 10) begin nerr++; $display("FAIL single_count: got %0d required 10", outs - base); end
   endtask

   task automatic test_round_robin();
      int base, eg;
      pulse_reset(); step();
      base = outs; glog.delete();
      for (int q = 0; q < NUM_Q; q++) fill(q, 8);
      repeat (40) step();
      for (int i = 0; i < 40; i++) begin
         eg = (i >= 1 && i <= 32) ? ((i - 1) / MAX_BURST) % NUM_Q : -1;
         nvec++;
         if (glog[i] !== eg) begin nerr++; $display("FAIL rr_grant[%0d]: got %0d required %0d", i, glog[i], eg); end
      end
      nvec++; if (outs - base !== 32) begin nerr++; $display("FAIL rr_count: got %0d required 32", outs - base); end
   endtask

   task automatic test_last_word();
      int base, eg;
      pulse_reset(); step();
      base = outs; glog.delete();
      fill(2, 1);
      repeat (8) step();
      for (int i = 0; i < 8; i++) begin
         eg = (i == 1) ? 2 : -1;
         nvec++;
         if (glog[i] !== eg) begin nerr++; $display("FAIL last_grant[%0d]: got %0d required %0d", i, glog[i], eg); end
      end
      nvec++; if (outs - base !== 1) begin nerr++; $display("FAIL last_count: got %0d required 1", outs - base); end
   endtask

   task automatic test_backpressure();
      int base, ngr;
      pulse_reset(); step();
      base = outs; glog.delete();
      fill(0, 8); fill(1, 8);
      repeat (5) step();
      out_ready = 1'b0;
      repeat (8) step();
      out_ready = 1'b1;
      repeat (30) step();
      for (int i = 5; i <= 12; i++) begin
         nvec++;
         if (glog[i] !== -1) begin nerr++; $display("FAIL bp_stall_grant[%0d]: got %0d required -1", i, glog[i]); end
      end
      ngr = 0;
      foreach (glog[i]) if (glog[i] != -1) ngr++;
      nvec++; if (ngr !== 16) begin nerr++; $display("FAIL bp_grants: got %0d required 16", ngr); end
      nvec++; if (outs - base !== 16) begin nerr++; $display("FAIL bp_count: got %0d required 16", outs - base); end
      nvec++; if (exp_data.size() !== 0) begin nerr++; $display("FAIL bp_leftover: got %0d words required 0", exp_data.size()); end
   endtask

   task automatic test_reset_mid_burst();
      int base;
      pulse_reset(); step();
      out_ready = 1'b0;
      fill(1, 3);
      repeat (6) step();
      out_ready = 1'b1; sclr = 1'b1;
      @(negedge clock);
      nvec++; if (q_rreq !== 4'b0010) begin nerr++; $display("FAIL mid_pre_rreq: got %b required 0010", q_rreq); end
      nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL mid_pre_valid: got %b required 1", out_valid); end
      step(); sclr = 1'b0;
      @(negedge clock);
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL mid_post_valid: got %b required 0", out_valid); end
      nvec++; if (q_rreq !== '0) begin nerr++; $display("FAIL mid_post_rreq: got %b required 0", q_rreq); end
      nvec++; if (out_data !== '0) begin nerr++; $display("FAIL mid_post_data: got %h required 0", out_data); end
      step();
      base = outs; olog.delete(); glog.delete();
      fill(0, 3); fill(1, 3);
      repeat (12) step();
      nvec++; if (glog[0] !== -1) begin nerr++; $display("FAIL mid_grant0: got %0d required -1", glog[0]); end
      nvec++; if (glog[1] !== 0) begin nerr++; $display("FAIL mid_first_grant: got %0d required 0", glog[1]); end
      nvec++; if (outs - base !== 6) begin nerr++; $display("FAIL mid_count: got %0d required 6", outs - base); end
      nvec++;
      if (olog.size() == 0) begin nerr++; $display("FAIL mid_first_qid: got none required 0"); end
      else if (olog[0] !== 0) begin nerr++; $display("FAIL mid_first_qid: got %0d required 0", olog[0]); end
   endtask

   task automatic test_rotation();
      int base;
      int exp_g [20];
      exp_g = '{-1, 1, 1, 3, 3, 3, 3, 0, 0, 0, 0, 3, 3, 3, 3, -1, -1, -1, -1, -1};
      pulse_reset(); step();
      base = outs; glog.delete();
      fill(1, 2); fill(3, 8);
      step(); step();
      fill(0, 4);
      repeat (18) step();
      for (int i = 0; i < 20; i++) begin
         nvec++;
         if (glog[i] !== exp_g[i]) begin nerr++; $display("FAIL rot_grant[%0d]: got %0d required %0d", i, glog[i], exp_g[i]); end
      end
      nvec++; if (outs - base !== 14) begin nerr++; $display("FAIL rot_count: got %0d required 14", outs - base); end
   endtask

   initial begin
      test_reset();
      test_single_stream();
      test_round_robin();
      test_last_word();
      test_backpressure();
      test_reset_mid_burst();
      test_rotation();
      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
